// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// CLA group width, per-stage side-band record and the saturation clamp helper.
package cla_pkg;

    localparam int GROUP     = 4;
    // Widest operand the clamp helper can serve.
    localparam int SAT_MAX_W = 64;

    // Control record that travels with each beat through the pipeline.
    // carry is the carry out of the segment computed in that stage.
    typedef struct packed {
        logic valid;
        logic sub;
        logic sat;
        logic carry;
    } side_t;

    // Saturation value for an overflowed (width+1)-bit exact sum: the most
    // positive width-bit value when the true result is positive, the most
    // negative one otherwise. Only the low width bits of the return are meaningful.
    function automatic logic [SAT_MAX_W-1:0] sat_clamp(input logic [SAT_MAX_W:0] sum,
                                                       input int unsigned     width);
        logic [SAT_MAX_W-1:0] min_val;
        logic [6:0]           sign_idx;
        sign_idx = 7'(width);
        min_val  = SAT_MAX_W'(1) << (width - 1);
        if (sum[sign_idx]) begin
            return min_val;
        end
        return min_val - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: internal carries are flat
// sum-of-products of the bit propagate/generate terms, and the group
// propagate/generate pair lets the parent look ahead across groups.
module cla_group4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg,
    output logic       cout
);

    logic c1, c2, c3;

    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign gp   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign cout = gg | (gp & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined signed add/subtract. Stage k adds operand segment k with 4-bit
// CLA groups plus group lookahead, registers the segment carry for stage k+1,
// and forwards the operands and the lower result segments. The last stage
// assembles the exact WIDTH+1 sum, overflow, optional saturation and flags.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    input  logic                    sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH:0]   sum,
    output logic signed [WIDTH-1:0] res_sat,
    output logic                    ovf,
    output logic                    cout,
    output logic                    zero,
    output logic                    neg
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / GROUP;

    // Stage inputs (from the ports for stage 0, from the previous stage otherwise)
    logic signed [WIDTH-1:0] a_src    [STAGES];
    logic signed [WIDTH-1:0] b_src    [STAGES];
    logic        [WIDTH-1:0] res_src  [STAGES];
    side_t                   side_src [STAGES];
    // Stage register outputs
    logic signed [WIDTH-1:0] a_q      [STAGES];
    logic signed [WIDTH-1:0] b_q      [STAGES];
    logic        [WIDTH-1:0] res_q    [STAGES];
    side_t                   side_q   [STAGES];
    logic [STAGES-1:0]       adv;

    // A stage moves when it is empty or its successor moves; the last stage
    // moves when the consumer takes the result or nothing is presented.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !side_q[STAGES-1].valid || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = !side_q[i].valid || adv[i+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic signed [WIDTH-1:0] a_p;
        logic signed [WIDTH-1:0] b_p;
        logic        [WIDTH-1:0] res_p;
        logic        [WIDTH-1:0] res_nx;
        side_t                   side_p;
        side_t                   side_nx;
        logic        [NGRP:0]    gc;
        logic        [NGRP-1:0]  gp;
        logic        [NGRP-1:0]  gg;
        logic        [NGRP-1:0]  unused_cout;
        logic        [SEG-1:0]   seg_s;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1: the +1 enters as the carry into segment 0.
            assign a_src[k]    = a;
            assign b_src[k]    = sub ? ~b : b;
            assign res_src[k]  = '0;
            assign side_src[k] = '{valid: in_valid, sub: sub, sat: sat, carry: sub};
        end else begin : g_body
            assign a_src[k]    = a_q[k-1];
            assign b_src[k]    = b_q[k-1];
            assign res_src[k]  = res_q[k-1];
            assign side_src[k] = side_q[k-1];
        end

        assign a_q[k]    = a_p;
        assign b_q[k]    = b_p;
        assign res_q[k]  = res_p;
        assign side_q[k] = side_p;

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            localparam int LSB = k * SEG + j * GROUP;
            cla_group4 u_grp (
                .p    (a_src[k][LSB +: GROUP] ^ b_src[k][LSB +: GROUP]),
                .g    (a_src[k][LSB +: GROUP] & b_src[k][LSB +: GROUP]),
                .cin  (gc[j]),
                .s    (seg_s[j*GROUP +: GROUP]),
                .gp   (gp[j]),
                .gg   (gg[j]),
                .cout (unused_cout[j])
            );
        end

        // Group lookahead: every group carry is a flat OR of G/P products back to the segment carry-in
        always_comb begin
            logic pp;
            pp    = 1'b0;
            gc    = '0;
            gc[0] = side_src[k].carry;
            for (int j = 0; j < NGRP; j++) begin
                gc[j+1] = gg[j];
                pp      = gp[j];
                for (int i = j - 1; i >= 0; i--) begin
                    gc[j+1] = gc[j+1] | (pp & gg[i]);
                    pp      = pp & gp[i];
                end
                gc[j+1] = gc[j+1] | (pp & side_src[k].carry);
            end
        end

        // Insert this stage's segment into the forwarded partial result
        always_comb begin
            res_nx                 = res_src[k];
            res_nx[k*SEG +: SEG]   = seg_s;
        end

        assign side_nx = '{valid: side_src[k].valid, sub: side_src[k].sub,
                           sat: side_src[k].sat, carry: gc[NGRP]};

        // Stage k control: valid bit and side-band, cleared by reset so in-flight beats vanish
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                side_p <= '0;
            end else if (adv[k]) begin
                side_p <= side_nx;
            end
        end

        // Stage k datapath: operands and partial result, no reset needed
        always_ff @(posedge clk) begin
            if (adv[k]) begin
                a_p   <= a_src[k];
                b_p   <= b_src[k];
                res_p <= res_nx;
            end
        end
    end

    // Final assembly from the last stage
    logic             ext_msb;
    logic [WIDTH:0]   sum_raw;
    logic [WIDTH-1:0] clamp;
    logic [WIDTH-1:0] res_raw;
    logic             ovf_raw;
    logic             unused_tail;

    // Bit WIDTH of the sign-extended sum: sign(A) ^ sign(b_eff) ^ carry out of bit WIDTH-1.
    assign ext_msb = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ side_q[STAGES-1].carry;
    assign sum_raw = {ext_msb, res_q[STAGES-1]};
    assign ovf_raw = sum_raw[WIDTH] != sum_raw[WIDTH-1];
    assign clamp   = WIDTH'(sat_clamp((SAT_MAX_W+1)'(sum_raw), WIDTH));
    assign res_raw = (side_q[STAGES-1].sat && ovf_raw) ? clamp : sum_raw[WIDTH-1:0];

    // Operand low bits and the mode bit are fully consumed before the last stage.
    assign unused_tail = ^{a_q[STAGES-1][WIDTH-2:0], b_q[STAGES-1][WIDTH-2:0],
                           side_q[STAGES-1].sub};

    assign out_valid = side_q[STAGES-1].valid;

    // Present the result only with a valid beat so every output reads zero when idle or in reset
    always_comb begin
        sum     = '0;
        res_sat = '0;
        ovf     = 1'b0;
        cout    = 1'b0;
        zero    = 1'b0;
        neg     = 1'b0;
        if (out_valid) begin
            sum     = sum_raw;
            res_sat = res_raw;
            ovf     = ovf_raw;
            cout    = side_q[STAGES-1].carry;
            zero    = (res_raw == '0);
            neg     = res_raw[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: an 8-bit/2-stage instance for directed vectors,
// backpressure, throughput and mid-flight reset, and a 32-bit/4-stage
// instance swept with random operands against an integer reference.
module tb_cla_addsub_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // 8-bit, 2-stage instance
    logic       in_valid8, in_ready8, sub8, sat8, out_valid8, out_ready8;
    logic [7:0] a8, b8, res8;
    logic [8:0] sum8;
    logic       ovf8, cout8, zero8, neg8;

    // 32-bit, 4-stage instance
    logic        in_valid32, in_ready32, sub32, sat32, out_valid32, out_ready32;
    logic [31:0] a32, b32, res32;
    logic [32:0] sum32;
    logic        ovf32, cout32, zero32, neg32;

    cla_addsub_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .sat(sat8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .res_sat(res8), .ovf(ovf8), .cout(cout8), .zero(zero8), .neg(neg8)
    );

    cla_addsub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32), .sat(sat32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .res_sat(res32), .ovf(ovf32), .cout(cout32), .zero(zero32), .neg(neg32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Integer reference: a +/- b evaluated exactly, then reduced to the port widths.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, input logic tv,
                                  output logic [32:0] e_sum, output logic [31:0] e_res,
                                  output logic e_ovf, output logic e_cout);
        longint mask_w, ua, ub, sa, sb, r, mx, mn;
        mask_w = (longint'(1) << w) - 1;
        ua     = longint'(av) & mask_w;
        ub     = longint'(bv) & mask_w;
        e_cout = (((ua + (sv ? (~ub & mask_w) : ub) + longint'(sv)) >> w) & 1) != 0;
        sa     = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb     = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        r      = sv ? sa - sb : sa + sb;
        mx     = (longint'(1) << (w - 1)) - 1;
        mn     = -(longint'(1) << (w - 1));
        e_ovf  = (r > mx) || (r < mn);
        e_sum  = 33'(r & ((longint'(1) << (w + 1)) - 1));
        e_res  = 32'(((e_ovf && tv) ? ((r > 0) ? mx : mn) : r) & mask_w);
    endfunction

    // One beat through the 8-bit pipe with hand-computed expectations.
    task automatic vec8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic tv, input logic [8:0] e_sum,
                        input logic [7:0] e_res, input logic e_ovf, input logic e_cout,
                        input logic e_zero, input logic e_neg);
        @(negedge clk);
        a8 = av; b8 = bv; sub8 = sv; sat8 = tv; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1 check({tag, "/in_ready"}, in_ready8, 1);
        @(negedge clk);
        in_valid8 = 1'b0; a8 = ~av; b8 = ~bv; sub8 = ~sv; sat8 = ~tv;
        #1 check({tag, "/early_valid"}, out_valid8, 0);
        @(negedge clk);
        #1;
        check({tag, "/out_valid"}, out_valid8, 1);
        check({tag, "/sum"}, sum8, e_sum);
        check({tag, "/res_sat"}, res8, e_res);
        check({tag, "/ovf"}, ovf8, e_ovf);
        check({tag, "/cout"}, cout8, e_cout);
        check({tag, "/zero"}, zero8, e_zero);
        check({tag, "/neg"}, neg8, e_neg);
        @(negedge clk);
        #1 check({tag, "/consumed"}, out_valid8, 0);
    endtask

    logic [7:0] sa8 [8] = '{8'd100, 8'h9C, 8'd127, 8'h80, 8'd0, 8'd1, 8'd55, 8'hF0};
    logic [7:0] sb8 [8] = '{8'd50, 8'd50, 8'd127, 8'h7F, 8'd0, 8'hFF, 8'd77, 8'h10};
    logic       ss8 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       st8 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Stream n beats back-to-back into the 8-bit pipe, out_ready low for cycles st_lo..st_hi.
    task automatic stream8(input string tag, input int n, input int st_lo, input int st_hi,
                           input int max_cyc);
        int          tx = 0, rx = 0, cyc = 0;
        logic        held = 1'b0;
        logic [8:0]  last_sum = '0;
        logic [7:0]  last_res = '0;
        logic [32:0] es;
        logic [31:0] er;
        logic        eo, ec;
        while (rx < n && cyc < max_cyc) begin
            @(negedge clk);
            out_ready8 = !(cyc >= st_lo && cyc <= st_hi);
            in_valid8  = (tx < n);
            if (tx < n) begin
                a8 = sa8[tx]; b8 = sb8[tx]; sub8 = ss8[tx]; sat8 = st8[tx];
            end
            #1;
            check({tag, "/in_ready"}, in_ready8, ((tx - rx) < 2) || out_ready8);
            if (held) begin
                check({tag, "/hold_valid"}, out_valid8, 1);
                check({tag, "/hold_sum"}, sum8, last_sum);
                check({tag, "/hold_res"}, res8, last_res);
            end
            if (out_valid8 && out_ready8) begin
                model(8, {24'b0, sa8[rx]}, {24'b0, sb8[rx]}, ss8[rx], st8[rx], es, er, eo, ec);
                check({tag, "/sum"}, sum8, es[8:0]);
                check({tag, "/res_sat"}, res8, er[7:0]);
                check({tag, "/ovf"}, ovf8, eo);
                check({tag, "/cout"}, cout8, ec);
                rx++;
            end
            held     = out_valid8 && !out_ready8;
            last_sum = sum8;
            last_res = res8;
            if (in_valid8 && in_ready8) tx++;
            cyc++;
        end
        check({tag, "/beats"}, rx, n);
        @(negedge clk);
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        #1 check({tag, "/drained"}, out_valid8, 0);
    endtask

    // Random sweep of the 32-bit/4-stage pipe with random backpressure.
    task automatic sweep32(input int n);
        logic [31:0] wa [48];
        logic [31:0] wb [48];
        logic        ws [48];
        logic        wt [48];
        int          tx = 0, rx = 0, cyc = 0;
        logic [32:0] es;
        logic [31:0] er;
        logic        eo, ec;
        wa[0] = 32'h7FFF_FFFF; wb[0] = 32'h0000_0001; ws[0] = 1'b0; wt[0] = 1'b1;
        wa[1] = 32'h8000_0000; wb[1] = 32'h0000_0001; ws[1] = 1'b1; wt[1] = 1'b1;
        wa[2] = 32'h8000_0000; wb[2] = 32'h8000_0000; ws[2] = 1'b0; wt[2] = 1'b0;
        wa[3] = 32'hFFFF_FFFF; wb[3] = 32'hFFFF_FFFF; ws[3] = 1'b1; wt[3] = 1'b0;
        wa[4] = 32'h0000_FFFF; wb[4] = 32'h0000_0001; ws[4] = 1'b0; wt[4] = 1'b0;
        for (int i = 5; i < n; i++) begin
            wa[i] = $urandom; wb[i] = $urandom;
            ws[i] = 1'($urandom_range(0, 1)); wt[i] = 1'($urandom_range(0, 1));
        end
        while (rx < n && cyc < 400) begin
            @(negedge clk);
            out_ready32 = ($urandom_range(0, 3) != 0);
            in_valid32  = (tx < n);
            if (tx < n) begin
                a32 = wa[tx]; b32 = wb[tx]; sub32 = ws[tx]; sat32 = wt[tx];
            end
            #1;
            if (out_valid32 && out_ready32) begin
                model(32, wa[rx], wb[rx], ws[rx], wt[rx], es, er, eo, ec);
                check("w32/sum", sum32, es);
                check("w32/res_sat", res32, er);
                check("w32/ovf", ovf32, eo);
                check("w32/cout", cout32, ec);
                check("w32/zero", zero32, er == 32'd0);
                check("w32/neg", neg32, er[31]);
                rx++;
            end
            if (in_valid32 && in_ready32) tx++;
            cyc++;
        end
        check("w32/beats", rx, n);
        @(negedge clk);
        in_valid32 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; sat8 = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; sat32 = 1'b0;
        #1;
        check("rst/out_valid", out_valid8, 0);
        check("rst/sum", sum8, 0);
        check("rst/res_sat", res8, 0);
        check("rst/flags", {ovf8, cout8, zero8, neg8}, 0);
        check("rst/out_valid32", out_valid32, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst/in_ready", in_ready8, 1);
        check("rst/in_ready32", in_ready32, 1);

        vec8("sub_neg",  8'd120, 8'd122, 1'b1, 1'b0, 9'h1FE, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
        vec8("add_wrap", 8'd126, 8'd126, 1'b0, 1'b0, 9'h0FC, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b1);
        vec8("add_sat",  8'd126, 8'd126, 1'b0, 1'b1, 9'h0FC, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        vec8("neg_sat",  8'h80,  8'd1,   1'b1, 1'b1, 9'h17F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        vec8("zero",     8'd30,  8'd30,  1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        stream8("stall", 6, 3, 6, 30);
        stream8("thru", 8, 99, 0, 10);

        // Two beats parked in the pipe, then reset between clock edges
        @(negedge clk);
        out_ready8 = 1'b0; in_valid8 = 1'b1; a8 = 8'd5; b8 = 8'd3; sub8 = 1'b0; sat8 = 1'b0;
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; sub8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        #1 check("mid/loaded", out_valid8, 1);
        #1 rst = 1'b1;
        #1;
        check("mid/async_valid", out_valid8, 0);
        check("mid/async_sum", sum8, 0);
        @(negedge clk);
        rst = 1'b0; out_ready8 = 1'b1;
        #1 check("mid/in_ready", in_ready8, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("mid/no_stale", out_valid8, 0);
        end

        sweep32(40);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
        $fatal(1);
    end

endmodule
